// File: rtl/mirror_step_seq.sv
// mirror_step_seq: issues the iteration-index stream 0..N-1 to the mirror step
// pipeline, collects the in-order thetaStep results, tags them with their
// index and hands them downstream through a show-ahead FIFO. A credit scheme
// (outstanding + buffered <= DEPTH_P) guarantees the FIFO can never overflow.
module mirror_step_seq #(
  parameter int POINTS_PER_LINE_P  = 360,
  parameter int NUMBER_OF_FRAMES_P = 5,
  parameter int DEPTH_P            = 16
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        theta_iteration_valid_o,
  output logic [15:0] theta_iteration_o,
  input  logic        thetaStep_it_valid_i,
  input  logic [31:0] thetaStep_it_i,
  output logic        step_valid_o,
  output logic [31:0] step_o,
  output logic [15:0] step_idx_o,
  output logic        step_last_o,
  input  logic        step_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int N_P  = POINTS_PER_LINE_P * NUMBER_OF_FRAMES_P;
  localparam int AW_P = $clog2(DEPTH_P);
  localparam int CW_P = AW_P + 1;
  localparam int EW_P = 49;

  localparam logic [16:0]   N_L        = 17'(N_P);
  localparam logic [15:0]   LAST_IDX_L = 16'(N_P - 1);
  localparam logic [CW_P:0] DEPTH_L    = (CW_P + 1)'(DEPTH_P);
  localparam logic [CW_P-1:0] FULL_L   = CW_P'(DEPTH_P);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [16:0]         issue_idx_r;
  logic [16:0]         issue_base_s;
  logic [CW_P-1:0]     outstanding_r;
  logic [15:0]         ret_idx_r;
  logic [CW_P-1:0]     fifo_cnt_r;
  logic [AW_P-1:0]     wr_ptr_r;
  logic [AW_P-1:0]     rd_ptr_r;
  logic [EW_P-1:0]     mem_r [DEPTH_P];
  logic [EW_P-1:0]     head_s;
  logic                theta_valid_r;
  logic [15:0]         theta_idx_r;
  logic                done_r;
  logic                error_r;

  logic                credit_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                issue_s;
  logic                ret_s;
  logic                ret_adv_s;
  logic                push_s;
  logic                flush_s;
  logic                err_set_s;
  logic                err_clr_s;
  logic                done_nx_s;
  logic                sweep_clr_s;

  // Credit and FIFO handshake terms from registered state only, so returns and
  // pops in the current cycle are credited one cycle later.
  always_comb begin
    credit_s    = (({1'b0, outstanding_r} + {1'b0, fifo_cnt_r}) < DEPTH_L);
    fifo_full_s = (fifo_cnt_r == FULL_L);
    pop_s       = (fifo_cnt_r != {CW_P{1'b0}}) && step_ready_i;
  end

  // Next-state, issue decision and result-return classification.
  always_comb begin
    state_nx_s  = state_r;
    issue_s     = 1'b0;
    ret_s       = 1'b0;
    ret_adv_s   = 1'b0;
    push_s      = 1'b0;
    flush_s     = 1'b0;
    err_set_s   = 1'b0;
    err_clr_s   = 1'b0;
    done_nx_s   = 1'b0;
    sweep_clr_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // start_i wins over abort_i; index 0 goes out on the start edge so it
        // is visible the cycle right after start_i is sampled.
        if (start_i) begin
          state_nx_s  = ST_RUN;
          issue_s     = 1'b1;
          sweep_clr_s = 1'b1;
          err_clr_s   = 1'b1;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_nx_s = ST_FLUSH;
          flush_s    = 1'b1;
        end else if (issue_idx_r == N_L) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
          issue_s    = credit_s;
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_nx_s = ST_FLUSH;
          flush_s    = 1'b1;
        end else if ((outstanding_r == {CW_P{1'b0}}) &&
                     (fifo_cnt_r == {CW_P{1'b0}}) && !pop_s) begin
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (outstanding_r == {CW_P{1'b0}}) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FLUSH;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    // A returning result is either discarded (flush), dropped as an error
    // (nothing outstanding / idle / FIFO overflow) or pushed with its tag.
    if (thetaStep_it_valid_i) begin
      if (state_r == ST_IDLE) begin
        err_set_s = 1'b1;
      end else if ((state_r == ST_FLUSH) || flush_s) begin
        ret_s = (outstanding_r != {CW_P{1'b0}});
      end else if (outstanding_r == {CW_P{1'b0}}) begin
        err_set_s = 1'b1;
      end else begin
        ret_s     = 1'b1;
        ret_adv_s = 1'b1;
        if (fifo_full_s && !pop_s) begin
          err_set_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end
    end else begin
      ret_s = 1'b0;
    end
  end

  // Index handed out on an issue; a new sweep restarts from zero.
  always_comb begin
    if (sweep_clr_s) begin
      issue_base_s = 17'd0;
    end else begin
      issue_base_s = issue_idx_r;
    end
  end

  // Control state, sweep counters and registered status outputs.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_r       <= ST_IDLE;
      issue_idx_r   <= 17'd0;
      outstanding_r <= {CW_P{1'b0}};
      ret_idx_r     <= 16'd0;
      theta_valid_r <= 1'b0;
      theta_idx_r   <= 16'd0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      issue_idx_r   <= issue_base_s + {16'd0, issue_s};
      theta_valid_r <= issue_s;
      theta_idx_r   <= issue_s ? issue_base_s[15:0] : 16'd0;
      done_r        <= done_nx_s;
      case ({issue_s, ret_s})
        2'b10:   outstanding_r <= outstanding_r + CW_P'(1);
        2'b01:   outstanding_r <= outstanding_r - CW_P'(1);
        default: outstanding_r <= outstanding_r;
      endcase
      if (sweep_clr_s) begin
        ret_idx_r <= 16'd0;
      end else if (ret_adv_s) begin
        ret_idx_r <= ret_idx_r + 16'd1;
      end
      if (err_set_s) begin
        error_r <= 1'b1;
      end else if (err_clr_s) begin
        error_r <= 1'b0;
      end
    end
  end

  // FIFO pointers and fill count; abort empties the FIFO on the abort edge.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_r   <= {AW_P{1'b0}};
      rd_ptr_r   <= {AW_P{1'b0}};
      fifo_cnt_r <= {CW_P{1'b0}};
    end else if (flush_s) begin
      wr_ptr_r   <= {AW_P{1'b0}};
      rd_ptr_r   <= {AW_P{1'b0}};
      fifo_cnt_r <= {CW_P{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW_P'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW_P'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CW_P'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CW_P'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // FIFO storage: {result, index, last}; contents need no reset since the
  // outputs are gated by the fill count.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {thetaStep_it_i, ret_idx_r, (ret_idx_r == LAST_IDX_L)};
    end
  end

  // Show-ahead head entry, forced to zero while the FIFO is empty.
  always_comb begin
    if (fifo_cnt_r != {CW_P{1'b0}}) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = {EW_P{1'b0}};
    end
  end

  assign theta_iteration_valid_o = theta_valid_r;
  assign theta_iteration_o       = theta_idx_r;
  assign step_valid_o            = (fifo_cnt_r != {CW_P{1'b0}});
  assign step_o                  = head_s[48:17];
  assign step_idx_o              = head_s[16:1];
  assign step_last_o             = head_s[0];
  assign busy_o                  = (state_r != ST_IDLE);
  assign done_o                  = done_r;
  assign error_o                 = error_r;

endmodule

// File: doc/mirror_step_seq.md
Name: mirror_step_seq

Overview:
- Initiator and collector for the mirror step pipeline.
- Issues the iteration-index stream 0..N-1, where N = POINTS_PER_LINE_P*NUMBER_OF_FRAMES_P, on the 16-bit iteration interface.
- Collects the returned float thetaStep results in order, tags each with its index, and delivers them downstream over a ready/valid interface.
- Credit-based flow control bounds results in flight, so a stalled consumer never loses a result.

Parameters:
POINTS_PER_LINE_P, 360, points per scan line
NUMBER_OF_FRAMES_P, 5, frames per sweep; N = POINTS_PER_LINE_P*NUMBER_OF_FRAMES_P, must satisfy 1 <= N <= 65536
DEPTH_P, 16, result FIFO depth and credit limit; power of 2, at least 2

Ports:
clk_i  in  1  clock
nrst_i  in  1  async active-low reset
start_i  in  1  begin sweep (sampled in IDLE only)
abort_i  in  1  abandon sweep, flush
theta_iteration_valid_o  in/out: out  1  index valid (1-cycle pulse per index)
theta_iteration_o  out  16  index issued
thetaStep_it_valid_i  in  1  result valid from step pipeline
thetaStep_it_i  in  32  result, IEEE-754 single
step_valid_o  out  1  downstream result valid
step_o  out  32  downstream result
step_idx_o  out  16  index of step_o
step_last_o  out  1  step_idx_o == N-1
step_ready_i  in  1  downstream ready
busy_o  out  1  state != IDLE
done_o  out  1  1-cycle pulse at normal sweep completion
error_o  out  1  sticky: result arrived with zero outstanding, or FIFO push while full

Behaviour:
- Reset (async): state IDLE; all counters 0; FIFO empty. All outputs 0: theta_iteration_*, step_*, busy_o, done_o, error_o. Reset mid-sweep abandons everything. Results arriving after reset release with outstanding == 0 set error_o.
- Counters: issue_idx (17b), outstanding (0..DEPTH_P), ret_idx (16b, index of next returning result), fifo_cnt (0..DEPTH_P).
- Credit: issue allowed iff outstanding + fifo_cnt < DEPTH_P. Same-cycle pops and returns are not credited until the next cycle.
- IDLE: start_i=1 -> RUN. Clear issue_idx and ret_idx; clear error_o. start_i in any other state is ignored.
- RUN: each cycle with credit and issue_idx < N, register theta_iteration_valid_o=1 and theta_iteration_o=issue_idx, then issue_idx++ and outstanding++.
  - First index is visible the cycle after start_i is sampled.
  - Maximum rate is one index per cycle.
  - Once issue_idx == N -> DRAIN.
- DRAIN: no issue. When outstanding==0 and fifo_cnt==0 and no pop this cycle -> IDLE, with done_o=1 for one cycle.
- Result return, any state except FLUSH: thetaStep_it_valid_i pushes {thetaStep_it_i, ret_idx, ret_idx==N-1} into the FIFO. Then ret_idx++ and outstanding--.
  - Results are assumed in order.
  - In IDLE, or with outstanding==0, a result is dropped and error_o is set.
- Simultaneous issue and return in one cycle: outstanding is unchanged.
- FIFO: show-ahead. step_valid_o = fifo_cnt != 0; step_o, step_idx_o and step_last_o come from the head entry.
  - Pop on step_valid_o & step_ready_i.
  - Push-to-valid latency: 1 cycle.
  - Simultaneous push and pop is allowed in any fill state: fifo_cnt is unchanged.
- abort_i (RUN or DRAIN) -> FLUSH.
  - FIFO is emptied on the next edge and step_valid_o drops.
  - Issue stops immediately.
  - Returning results are discarded, decrementing outstanding.
  - When outstanding==0 -> IDLE with no done_o.
  - abort_i in IDLE or FLUSH has no effect; start_i in FLUSH is ignored.
- abort_i and start_i together in IDLE: start wins.
- step_idx_o wraps never: ret_idx stops at N-1 by construction. With N=65536, issue_idx needs 17 bits.

Test Plan:
- POINTS=4, FRAMES=2, DEPTH=16, model pipeline latency 7 cycles, ready=1 → indices 0..7 on consecutive cycles; results out with idx 0..7 in order; last only on idx 7; one done_o pulse; busy_o drops the same cycle done_o asserts.
- N=40, DEPTH=16, ready=0 → exactly 16 indices issued (0..15), then the issue stall holds; step_valid_o stays 1 on idx 0. Raise ready → issue resumes at idx 16; all 40 results delivered in order.
- N=40, abort_i after 10 issued with 5 results returned → FIFO flushes next cycle; the 5 remaining returns are discarded; IDLE with no done_o. A new start_i re-issues from 0.
- Idle state, inject thetaStep_it_valid_i → error_o=1, FIFO stays empty. Next start_i clears error_o.
- Mid-RUN, nrst_i pulse low → all outputs 0 immediately. After release, busy_o=0 until start_i; late returns set error_o.
- start_i pulsed during RUN → ignored; index sequence is unbroken and exactly one done_o occurs.
